// File: rtl/pix16_to_pix8_narrower_pkg.sv
// -----------------------------------------------------------------------------
// pix16_to_pix8_narrower_pkg
// Shared definitions for the 16-to-8 bit pixel write-back narrower:
//   - frame-control state encoding
//   - pixel range limits used by the clamp
//   - default frame geometry (256x256 image)
//   - saturating increment helper for the 16-bit clamp-event counter
// -----------------------------------------------------------------------------
package pix16_to_pix8_narrower_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0]  PIX_MAX        = 8'hFF;
    localparam logic [7:0]  PIX_MIN        = 8'h00;
    localparam int          DEFAULT_PIXELS = 65536;
    localparam int          DEFAULT_CNT_W  = 17;
    localparam logic [15:0] SAT_CNT_MAX    = 16'hFFFF;

    // Increment that sticks at the maximum instead of wrapping to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] i_val);
        logic [15:0] w_res;
        if (i_val == SAT_CNT_MAX) begin
            w_res = i_val;
        end else begin
            w_res = i_val + 16'd1;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/pix16_to_pix8_narrower_pix_clamp8.sv
// -----------------------------------------------------------------------------
// pix_clamp8
// Combinational 16-bit to 8-bit pixel narrowing, reusable by any write-back
// path. Either clamps the value into 0..255 or keeps the low byte.
//
// Ports:
//   i_data   16-bit processor result (two's complement when SIGNED_IN=1)
//   i_trunc  1 = keep i_data[7:0]; 0 = clamp into 0..255
//   o_pix    narrowed pixel
//   o_sat    1 when the clamp changed the value (never set in trunc mode)
// -----------------------------------------------------------------------------
module pix_clamp8
    import pix16_to_pix8_narrower_pkg::*;
#(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic [15:0] i_data,
    input  logic        i_trunc,
    output logic [7:0]  o_pix,
    output logic        o_sat
);

    // Select clamped or truncated byte and flag clamp events.
    always_comb begin
        o_pix = i_data[7:0];
        o_sat = 1'b0;
        if (i_trunc) begin
            o_pix = i_data[7:0];
            o_sat = 1'b0;
        end else if (SIGNED_IN && i_data[15]) begin
            // Negative two's complement value floors at zero.
            o_pix = PIX_MIN;
            o_sat = 1'b1;
        end else if (i_data[15:8] != 8'h00) begin
            // Any set bit above the low byte means the value exceeds 255.
            o_pix = PIX_MAX;
            o_sat = 1'b1;
        end else begin
            o_pix = i_data[7:0];
            o_sat = 1'b0;
        end
    end

endmodule

// File: rtl/pix16_to_pix8_narrower.sv
// -----------------------------------------------------------------------------
// pix16_to_pix8_narrower
// Streaming write-back converter: takes 16-bit datapath results over a
// valid/ready handshake, narrows each to an 8-bit pixel, buffers it in a
// 2-entry FIFO and frames exactly PIXELS pixels per start pulse.
//
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   start         frame start pulse, honoured only while idle
//   mode_trunc    0 = clamp to 0..255, 1 = keep low byte (per accepted word)
//   in_valid/in_ready/in_data     upstream 16-bit word handshake
//   out_valid/out_ready/out_data  downstream 8-bit pixel handshake
//   out_last      marks the final pixel of the frame
//   sat_count     clamp events in the current frame (sticks at 0xFFFF)
//   busy          frame in progress (running or draining)
//   frame_done    one-cycle pulse when the frame has fully drained
// -----------------------------------------------------------------------------
module pix16_to_pix8_narrower
    import pix16_to_pix8_narrower_pkg::*;
#(
    parameter int PIXELS    = DEFAULT_PIXELS,
    parameter bit SIGNED_IN = 1'b1,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode_trunc,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic [15:0] sat_count,
    output logic        busy,
    output logic        frame_done
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_pix_cnt;
    logic [15:0]        r_sat_count;
    logic [8:0]         r_fifo_mem [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_fifo_cnt;
    logic               r_frame_done;

    logic               w_in_ready;
    logic               w_start;
    logic               w_push;
    logic               w_pop;
    logic               w_last;
    logic [7:0]         w_pix;
    logic               w_sat;

    // Acceptance looks only at registered state, so out_ready never reaches
    // in_ready combinationally; a full FIFO refuses even if it pops this cycle.
    assign w_in_ready = (r_state == ST_RUN) && (r_fifo_cnt < 2'd2);
    assign w_start    = start && (r_state == ST_IDLE);
    assign w_push     = in_valid && w_in_ready;
    assign w_pop      = (r_fifo_cnt != 2'd0) && out_ready;
    assign w_last     = (r_pix_cnt == CNT_W'(PIXELS - 1));

    pix_clamp8 #(
        .SIGNED_IN (SIGNED_IN)
    ) u_clamp (
        .i_data  (in_data),
        .i_trunc (mode_trunc),
        .o_pix   (w_pix),
        .o_sat   (w_sat)
    );

    // Frame-control next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_push && w_last) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (r_fifo_cnt == 2'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and registered frame completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= (r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE);
        end
    end

    // Per-frame pixel counter and clamp-event counter; both cleared by start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt   <= '0;
            r_sat_count <= 16'd0;
        end else if (w_start) begin
            r_pix_cnt   <= '0;
            r_sat_count <= 16'd0;
        end else begin
            if (w_push) begin
                r_pix_cnt <= r_pix_cnt + CNT_W'(1);
            end else begin
                r_pix_cnt <= r_pix_cnt;
            end
            if (w_push && w_sat) begin
                r_sat_count <= sat_inc16(r_sat_count);
            end else begin
                r_sat_count <= r_sat_count;
            end
        end
    end

    // Two-entry FIFO of {last, pixel}; simultaneous push/pop keeps the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_mem[0] <= 9'd0;
            r_fifo_mem[1] <= 9'd0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_fifo_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= {w_last, w_pix};
                r_wr_ptr             <= ~r_wr_ptr;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = (r_fifo_cnt != 2'd0);
    assign out_data   = r_fifo_mem[r_rd_ptr][7:0];
    assign out_last   = r_fifo_mem[r_rd_ptr][8];
    assign sat_count  = r_sat_count;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pix16_to_pix8_narrower.sv
// -----------------------------------------------------------------------------
// tb_pix16_to_pix8_narrower
// Self-checking bench. A transaction-level model (queue of expected pixels,
// frame flags, clamp-event count) predicts in_ready, out_valid, the head pixel
// and sat_count every cycle. Inputs change and outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_pix16_to_pix8_narrower;

    localparam int PIX    = 4;
    localparam bit SIGNED = 1'b1;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode_trunc;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] sat_count;
    logic        busy;
    logic        frame_done;

    int n_vec;
    int n_bad;

    // model state
    logic [8:0]  m_q [$];
    bit          m_run;
    bit          m_frame;
    int          m_cnt;
    int          m_sat;
    int          m_fd;

    logic [15:0] stim [PIX];

    pix16_to_pix8_narrower #(
        .PIXELS    (PIX),
        .SIGNED_IN (SIGNED),
        .CNT_W     (17)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode_trunc (mode_trunc),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .sat_count  (sat_count),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Narrowing rule written with plain integer arithmetic.
    function automatic void ref_narrow(input logic [15:0] d, input logic tr,
                                       output logic [7:0] b, output bit s);
        int v;
        v = SIGNED ? int'($signed(d)) : int'(d);
        s = 1'b0;
        if (tr) begin
            b = d[7:0];
        end else if (v < 0) begin
            b = 8'h00;
            s = 1'b1;
        end else if (v > 255) begin
            b = 8'hFF;
            s = 1'b1;
        end else begin
            b = v[7:0];
        end
    endfunction

    // One clock cycle: check outputs, drive inputs, advance the model.
    task automatic step(input logic v, input logic [15:0] d, input logic tr,
                        input logic ordy, input logic st, output bit acc);
        bit          exp_ir;
        bit          pop;
        bit          s;
        logic [7:0]  b;
        logic        lst;
        exp_ir = m_run && (m_q.size() < 2);
        check_eq("in_ready", 32'(in_ready), 32'(exp_ir));
        check_eq("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_eq("out_data", 32'(out_data), 32'(m_q[0][7:0]));
            check_eq("out_last", 32'(out_last), 32'(m_q[0][8]));
        end
        check_eq("sat_count", 32'(sat_count), 32'(m_sat));
        if (frame_done) m_fd++;
        in_valid   = v;
        in_data    = d;
        mode_trunc = tr;
        out_ready  = ordy;
        start      = st;
        acc = v && exp_ir;
        pop = (m_q.size() != 0) && ordy;
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            ref_narrow(d, tr, b, s);
            lst = (m_cnt == PIX - 1);
            m_q.push_back({lst, b});
            m_cnt++;
            if (s && m_sat < 65535) m_sat++;
            if (m_cnt == PIX) m_run = 1'b0;
        end
        if (st && !m_frame) begin
            m_frame = 1'b1;
            m_run   = 1'b1;
            m_cnt   = 0;
            m_sat   = 0;
        end
        if (m_frame && !m_run && m_q.size() == 0) m_frame = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // trunc_mode: 0 clamp, 1 trunc, 2 random per cycle.
    // start_at: loop cycle with an extra (ignored) start, -1 for none.
    // rst_after: reset once this many words are accepted, 0 for none.
    task automatic run_frame(input int trunc_mode, input int stall, input bit rnd_rdy,
                             input int start_at, input int rst_after);
        int   idx;
        int   cyc;
        bit   acc;
        logic tr;
        logic ordy;
        logic v;
        m_fd = 0;
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, acc);
        idx = 0;
        cyc = 0;
        while ((idx < PIX || m_q.size() != 0) && cyc < 400) begin
            v    = (idx < PIX);
            tr   = (trunc_mode == 2) ? 1'($urandom_range(0, 1)) : (trunc_mode == 1);
            ordy = (cyc >= stall) && (rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1);
            step(v, v ? stim[idx] : 16'h0000, tr, ordy, (cyc == start_at), acc);
            if (acc) idx++;
            cyc++;
            if (rst_after > 0 && idx == rst_after) begin
                rst = 1'b1;
                #1;
                check_eq("rst_out_valid", 32'(out_valid), 32'd0);
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_sat_count", 32'(sat_count), 32'd0);
                check_eq("rst_in_ready", 32'(in_ready), 32'd0);
                m_q.delete();
                m_run   = 1'b0;
                m_frame = 1'b0;
                m_cnt   = 0;
                m_sat   = 0;
                m_fd    = 0;
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, acc);
                check_eq("rst_no_frame_done", 32'(m_fd), 32'd0);
                return;
            end
        end
        check_eq("frame_timeout", 32'(cyc < 400), 32'd1);
        for (int i = 0; i < 10 && busy; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, acc);
        check_eq("busy_end", 32'(busy), 32'd0);
        check_eq("frame_done_count", 32'(m_fd), 32'd1);
    endtask

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        case ($urandom_range(0, 2))
            0:       w = 16'($urandom_range(0, 255));
            1:       w = 16'($urandom_range(256, 32767));
            default: w = 16'($urandom_range(32768, 65535));
        endcase
        return w;
    endfunction

    initial begin
        bit acc;
        n_vec = 0;
        n_bad = 0;
        m_run = 1'b0;
        m_frame = 1'b0;
        m_cnt = 0;
        m_sat = 0;
        m_fd = 0;
        rst = 1'b1;
        start = 1'b0;
        mode_trunc = 1'b0;
        in_valid = 1'b0;
        in_data = 16'h0000;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        check_eq("reset_out_valid", 32'(out_valid), 32'd0);
        check_eq("reset_in_ready", 32'(in_ready), 32'd0);
        check_eq("reset_out_data", 32'(out_data), 32'd0);
        check_eq("reset_out_last", 32'(out_last), 32'd0);
        check_eq("reset_sat_count", 32'(sat_count), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;

        // words offered while idle are not taken
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0123, 1'b0, 1'b1, 1'b0, acc);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // clamp frame with known results
        stim = '{16'h0064, 16'h0123, 16'hFF9C, 16'h00FF};
        run_frame(0, 0, 1'b0, -1, 0);
        check_eq("t1_sat_count", 32'(sat_count), 32'd2);

        // trunc frame
        stim = '{16'h0123, 16'hFF9C, 16'h0123, 16'hFF9C};
        run_frame(1, 0, 1'b0, -1, 0);
        check_eq("t2_sat_count", 32'(sat_count), 32'd0);

        // downstream stall: FIFO fills, head holds, then drains in order
        stim = '{16'h0011, 16'h0222, 16'h8000, 16'h0033};
        run_frame(0, 8, 1'b0, -1, 0);

        // continuous flow
        for (int i = 0; i < PIX; i++) stim[i] = rnd_word();
        run_frame(2, 0, 1'b0, -1, 0);

        // reset mid-frame, then a clean frame
        stim = '{16'h0123, 16'hFF9C, 16'h0050, 16'h0060};
        run_frame(0, 0, 1'b0, -1, 2);
        stim = '{16'h0001, 16'h7FFF, 16'h00FE, 16'hFFFF};
        run_frame(0, 0, 1'b0, -1, 0);
        check_eq("t5_sat_count", 32'(sat_count), 32'd2);

        // start pulsed mid-frame is ignored and does not clear sat_count
        stim = '{16'h0300, 16'hF000, 16'h0010, 16'h0400};
        run_frame(0, 0, 1'b0, 2, 0);
        check_eq("t6_sat_count", 32'(sat_count), 32'd3);

        // randomized frames with random back-pressure and mode
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < PIX; i++) stim[i] = rnd_word();
            run_frame(2, 0, 1'b1, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pix16_to_pix8_narrower.md
Name: pix16_to_pix8_narrower

Overview:
- Streaming converter from 16-bit processor datapath results back to 8-bit pixels for the image write-back path. It is the reverse direction of the existing 8-to-16 zero-extender.
- Accepts one 16-bit word per valid/ready handshake and narrows it by clamping or truncation.
- Buffers results in a 2-entry output FIFO and frames a fixed pixel count per start pulse.
- Reports saturation events and signals frame completion to the control FSM.

Parameters:
- PIXELS, 65536, pixels per frame (256x256 image); must be ≥1.
- SIGNED_IN, 1, 1 = in_data is two's complement; 0 = unsigned.
- CNT_W, 17, width of the internal pixel counter; must hold PIXELS.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- mode_trunc  in  1  0 = clamp to 0..255; 1 = keep in_data[7:0]. Sampled per accepted word.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  16  processor result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8  narrowed pixel.
- out_last  out  1  qualifies the final pixel of the frame.
- sat_count  out  16  clamp events in the current frame.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (async, rst=1): state IDLE, FIFO empty, pixel counter 0, sat_count 0. All outputs 0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on start. This clears sat_count and the pixel counter.
  - RUN→DRAIN on the handshake that accepts pixel number PIXELS.
  - DRAIN→IDLE when the FIFO is empty. frame_done is high for the single cycle in which state=IDLE follows DRAIN (registered).
  - start outside IDLE is ignored.
- Input acceptance: in_ready = (state==RUN) && (fifo_count<2).
  - in_ready is a function of registers only. There is no combinational path from out_ready to in_ready.
  - When the FIFO is full, in_ready=0 even if a pop occurs in the same cycle.
  - A word is accepted iff in_valid && in_ready.
  - in_valid in IDLE or DRAIN is not accepted and has no effect.
- Narrowing, applied at push time:
  - Clamp, SIGNED_IN=1: value <0 → 0x00; value >255 → 0xFF; otherwise low byte.
  - Clamp, SIGNED_IN=0: value >255 → 0xFF; otherwise low byte.
  - Trunc: in_data[7:0].
  - sat_count increments by 1 when clamp changes the value (clamp mode only). It saturates at 0xFFFF.
- FIFO: 2 entries, each storing {last, byte}.
  - last=1 on the entry for the PIXELS-th accepted word.
  - out_valid = (fifo_count != 0); out_data and out_last come from the head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle at count 1: count stays 1 and ordering is preserved.
  - Head data is stable while out_valid && !out_ready.
- Latency: accepted at edge N → visible on out_* after edge N (first cycle after acceptance). Throughput is 1 pixel/cycle with out_ready held high.
- Pixel counter counts accepted words only. It does not wrap: the frame ends at PIXELS.
- Reset mid-frame: all state is discarded immediately. No frame_done is issued. Partial FIFO contents are lost.

Decomposition:
- Shared package holds:
  - state encoding IDLE=2'd0, RUN=2'd1, DRAIN=2'd2;
  - PIX_MAX=8'hFF and PIX_MIN=8'h00;
  - the default frame size constant.
- The natural sub-module is pix_clamp8: a combinational 16→8 clamp/trunc plus a saturation flag, reusable by other write-back paths. The FIFO stays inline.

Test Plan:
1. PIXELS=4, clamp, out_ready=1; start, then in_data 0x0064, 0x0123, 0xFF9C, 0x00FF → out_data 0x64, 0xFF, 0x00, 0xFF. out_last only on the 4th. sat_count=2. frame_done pulses once after the 4th pop.
2. mode_trunc=1, in_data 0x0123, 0xFF9C → 0x23, 0x9C; sat_count=0.
3. out_ready=0, in_valid held with 3 words → 2 accepted, then in_ready=0 and out_data stable at the first byte. Raise out_ready → all 3 emerge in order; in_ready returns 1 the cycle after the first pop.
4. Continuous in_valid/out_ready for PIXELS=8 → 8 outputs on 8 consecutive cycles; fifo_count never exceeds 1.
5. Assert rst after 2 of 4 pixels accepted → same cycle: out_valid=0, busy=0, sat_count=0. A new start runs a full 4-pixel frame correctly.
6. start pulsed during RUN and in_valid asserted in IDLE → no state change and nothing accepted; sat_count is not cleared by the ignored start.
